alu_nbit_serial: RTL and testbench

//   Parametrised multi-cycle N-bit ALU: successor to the 1-bit ALU slice.

---
 rtl/alu_nbit_serial_if.sv | 60 ++++++
 rtl/alu_nbit_serial.sv | 207 ++++++++++++++++++++
 tb/tb_alu_nbit_serial.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_nbit_serial_if.sv
// ---------------------------------------------------------------------------
// alu_nbit_serial_if
// Handshake and data bundle between the operand register file, the serial
// ALU and the writeback stage.
//
// Signals:
//   in_valid / in_ready    request handshake (producer -> ALU)
//   op1, op2               WIDTH-bit operands
//   mode, opsel, cin       operation selection and carry/shift-in bit
//   out_valid / out_ready  result handshake (ALU -> consumer)
//   result                 WIDTH-bit result
//   cout, zero, neg        carry/shift-out bit and result flags
//   ovf                    signed overflow, only with ALU_SERIAL_OVF_EN
//
// Modports:
//   master  side that issues operations and consumes results
//   slave   the ALU itself
//
// Optional feature macro: ALU_SERIAL_OVF_EN (adds the ovf signal).
// ---------------------------------------------------------------------------
interface alu_nbit_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             mode;
    logic [2:0]       opsel;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             neg;
`ifdef ALU_SERIAL_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, op1, op2, mode, opsel, cin, out_ready,
        input  in_ready, out_valid, result, cout, zero, neg, ovf
    );

    modport slave (
        input  in_valid, op1, op2, mode, opsel, cin, out_ready,
        output in_ready, out_valid, result, cout, zero, neg, ovf
    );
`else
    modport master (
        output in_valid, op1, op2, mode, opsel, cin, out_ready,
        input  in_ready, out_valid, result, cout, zero, neg
    );

    modport slave (
        input  in_valid, op1, op2, mode, opsel, cin, out_ready,
        output in_ready, out_valid, result, cout, zero, neg
    );
`endif
endinterface

// File: rtl/alu_nbit_serial.sv
// ---------------------------------------------------------------------------
// alu_nbit_serial
// Multi-cycle N-bit ALU. Operands are captured on the accept edge and then
// processed LSB-first, SLICE bits per clock, with a registered carry linking
// consecutive slices. The result is presented with a valid/ready handshake
// and held stable until the consumer takes it.
//
// Parameters:
//   WIDTH  operand/result width (multiple of SLICE)
//   SLICE  bits processed per clock; WIDTH/SLICE busy cycles per operation
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_nbit_serial_if.slave (operands, controls, result, flags)
//
// Optional feature macro: ALU_SERIAL_OVF_EN
//   defined   -> signed overflow flag driven on bus.ovf
//   undefined -> no overflow logic
// ---------------------------------------------------------------------------
module alu_nbit_serial #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input logic              clk,
    input logic              rst_n,
    alu_nbit_serial_if.slave bus
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry_q;
    logic             mode_q;
    logic [2:0]       opsel_q;
    logic             cout_q;
    logic             zero_q;
    logic             neg_q;

    logic             accept;
    logic             last_slice;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] bx_sl;
    logic [SLICE-1:0] ar_sum;
    logic             ar_cout;
    logic             ar_cmsb;
    logic [SLICE:0]   sh;
    logic [SLICE-1:0] slice_res;
    logic             slice_cout;
    logic [WIDTH-1:0] res_next;

    assign accept     = (state == IDLE) && bus.in_valid;
    assign last_slice = (state == BUSY) && (cnt == LAST);
    assign a_sl       = a_sr[SLICE-1:0];
    assign b_sl       = b_sr[SLICE-1:0];

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. in_ready is only high in IDLE, so a result must be
    // taken before the next operation can be accepted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.in_valid)  state_next = BUSY;
            BUSY: if (cnt == LAST)   state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Second adder operand for this slice, selected from the captured B.
    always_comb begin
        bx_sl = '0;
        if (!opsel_q[2]) begin
            case (opsel_q[1:0])
                2'b00:   bx_sl = b_sl;
                2'b01:   bx_sl = ~b_sl;
                2'b10:   bx_sl = '0;
                default: bx_sl = '1;
            endcase
        end
    end

    // Ripple adder across one slice, seeded by the registered carry. The
    // carry entering the top bit is kept for overflow detection.
    always_comb begin
        logic c;
        c       = carry_q;
        ar_sum  = '0;
        ar_cmsb = 1'b0;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) ar_cmsb = c;
            ar_sum[i] = a_sl[i] ^ bx_sl[i] ^ c;
            c = (a_sl[i] & bx_sl[i]) | (c & (a_sl[i] ^ bx_sl[i]));
        end
        ar_cout = c;
    end

    // Slice result. For the left shift the registered carry holds cin on
    // the first slice and the previous slice's top A bit afterwards.
    always_comb begin
        sh         = {a_sl, carry_q};
        slice_res  = '0;
        slice_cout = 1'b0;
        if (!mode_q) begin
            slice_res  = ar_sum;
            slice_cout = ar_cout;
        end else if (opsel_q[2]) begin
            slice_res  = sh[SLICE-1:0];
            slice_cout = sh[SLICE];
        end else begin
            case (opsel_q[1:0])
                2'b00:   slice_res = a_sl & b_sl;
                2'b01:   slice_res = a_sl | b_sl;
                2'b10:   slice_res = a_sl ^ b_sl;
                default: slice_res = ~a_sl;
            endcase
        end
    end

    // Result slices enter at the top and shift down, so after N slices the
    // first (least significant) slice has reached bit 0.
    assign res_next = (res_sr >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));

    // Datapath: capture on accept, shift one slice per BUSY cycle, and
    // register the flags from the complete result on the final slice so
    // they stay frozen while the result waits in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            opsel_q <= 3'b000;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            a_sr    <= bus.op1;
            b_sr    <= bus.op2;
            mode_q  <= bus.mode;
            opsel_q <= bus.opsel;
            carry_q <= bus.cin;
        end else if (state == BUSY) begin
            a_sr    <= a_sr >> SLICE;
            b_sr    <= b_sr >> SLICE;
            res_sr  <= res_next;
            carry_q <= slice_cout;
            if (last_slice) begin
                cnt    <= '0;
                cout_q <= slice_cout;
                zero_q <= (res_next == '0);
                neg_q  <= res_next[WIDTH-1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef ALU_SERIAL_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (last_slice) begin
            ovf_q <= !mode_q && (ar_cmsb ^ ar_cout);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_sr;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;

endmodule

// File: tb/tb_alu_nbit_serial.sv
// ---------------------------------------------------------------------------
// tb_alu_nbit_serial
// Directed bench for alu_nbit_serial: an 8-bit/1-bit-slice instance and a
// 16-bit/4-bit-slice instance share clock and reset. Expected values are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_nbit_serial;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_nbit_serial_if #(.WIDTH(8))  b8 ();
    alu_nbit_serial_if #(.WIDTH(16)) b16 ();

    alu_nbit_serial #(.WIDTH(8), .SLICE(1)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8.slave)
    );

    alu_nbit_serial #(.WIDTH(16), .SLICE(4)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16.slave)
    );

    int total = 0;
    int bad   = 0;

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] obsResult(input bit wide);
        return wide ? b16.result : {8'h00, b8.result};
    endfunction

    function automatic logic obsOutValid(input bit wide);
        return wide ? b16.out_valid : b8.out_valid;
    endfunction

    function automatic logic obsInReady(input bit wide);
        return wide ? b16.in_ready : b8.in_ready;
    endfunction

    // Present an operation at a falling edge, let it be accepted on the
    // next rising edge, then scramble the inputs to show they were captured.
    task automatic acceptOp(input bit wide, input logic [15:0] a, input logic [15:0] b,
                            input logic m, input logic [2:0] op, input logic c);
        @(negedge clk);
        checkOutput("in_ready_idle", obsInReady(wide), 1'b1);
        if (wide) begin
            b16.op1 = a; b16.op2 = b; b16.mode = m; b16.opsel = op; b16.cin = c;
            b16.in_valid = 1'b1;
        end else begin
            b8.op1 = a[7:0]; b8.op2 = b[7:0]; b8.mode = m; b8.opsel = op; b8.cin = c;
            b8.in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        b8.in_valid  = 1'b0;
        b16.in_valid = 1'b0;
        b8.op1  = ~b8.op1;  b8.op2  = ~b8.op2;  b8.mode  = ~b8.mode;
        b8.opsel = ~b8.opsel; b8.cin = ~b8.cin;
        b16.op1 = ~b16.op1; b16.op2 = ~b16.op2; b16.mode = ~b16.mode;
        b16.opsel = ~b16.opsel; b16.cin = ~b16.cin;
        checkOutput("in_ready_busy", obsInReady(wide), 1'b0);
    endtask

    // Accept an operation and measure cycles until out_valid rises.
    task automatic applyStimulus(input bit wide, input logic [15:0] a, input logic [15:0] b,
                                 input logic m, input logic [2:0] op, input logic c,
                                 input int exp_lat, input string tag);
        int lat;
        acceptOp(wide, a, b, m, op, c);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (obsOutValid(wide)) break;
        end
        checkOutput({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic checkResult(input bit wide, input string tag, input logic [15:0] exp_res,
                               input logic exp_cout, input logic exp_zero,
                               input logic exp_neg, input logic exp_ovf);
        checkOutput({tag, "_result"}, obsResult(wide), exp_res);
        checkOutput({tag, "_cout"}, wide ? b16.cout : b8.cout, exp_cout);
        checkOutput({tag, "_zero"}, wide ? b16.zero : b8.zero, exp_zero);
        checkOutput({tag, "_neg"},  wide ? b16.neg  : b8.neg,  exp_neg);
`ifdef ALU_SERIAL_OVF_EN
        checkOutput({tag, "_ovf"},  wide ? b16.ovf  : b8.ovf,  exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("[TB] note: %s ovf expectation unknown", tag);
`endif
    endtask

    // Pulse out_ready for one cycle; the block must be idle right after.
    task automatic releaseResult(input bit wide);
        @(negedge clk);
        if (wide) b16.out_ready = 1'b1; else b8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b8.out_ready  = 1'b0;
        b16.out_ready = 1'b0;
        checkOutput("in_ready_after_release", obsInReady(wide), 1'b1);
        checkOutput("out_valid_after_release", obsOutValid(wide), 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        b8.in_valid = 1'b0;  b8.out_ready = 1'b0;  b8.op1 = '0;  b8.op2 = '0;
        b8.mode = 1'b0;  b8.opsel = 3'b000;  b8.cin = 1'b0;
        b16.in_valid = 1'b0; b16.out_ready = 1'b0; b16.op1 = '0; b16.op2 = '0;
        b16.mode = 1'b0; b16.opsel = 3'b000; b16.cin = 1'b0;

        // Reset state
        #3;
        checkOutput("rst_in_ready", b8.in_ready, 1'b1);
        checkOutput("rst_out_valid", b8.out_valid, 1'b0);
        checkResult(1'b0, "rst8", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst16_in_ready", b16.in_ready, 1'b1);
        checkResult(1'b1, "rst16", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic
        applyStimulus(1'b0, 16'h7F, 16'h01, 1'b0, 3'b000, 1'b0, 8, "add");
        checkResult(1'b0, "add", 16'h80, 1'b0, 1'b0, 1'b1, 1'b1);
        releaseResult(1'b0);
        applyStimulus(1'b0, 16'h05, 16'h05, 1'b0, 3'b001, 1'b1, 8, "sub");
        checkResult(1'b0, "sub", 16'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        releaseResult(1'b0);
        applyStimulus(1'b0, 16'hFF, 16'h33, 1'b0, 3'b010, 1'b1, 8, "inc");
        checkResult(1'b0, "inc", 16'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        releaseResult(1'b0);
        applyStimulus(1'b0, 16'h00, 16'h12, 1'b0, 3'b011, 1'b0, 8, "dec");
        checkResult(1'b0, "dec", 16'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        releaseResult(1'b0);
        applyStimulus(1'b0, 16'h7F, 16'h55, 1'b0, 3'b100, 1'b1, 8, "bx0");
        checkResult(1'b0, "bx0", 16'h80, 1'b0, 1'b0, 1'b1, 1'b1);
        releaseResult(1'b0);

        // Logic
        applyStimulus(1'b0, 16'hCC, 16'hAA, 1'b1, 3'b000, 1'b1, 8, "and");
        checkResult(1'b0, "and", 16'h88, 1'b0, 1'b0, 1'b1, 1'b0);
        releaseResult(1'b0);
        applyStimulus(1'b0, 16'hCC, 16'hAA, 1'b1, 3'b001, 1'b0, 8, "or");
        checkResult(1'b0, "or", 16'hEE, 1'b0, 1'b0, 1'b1, 1'b0);
        releaseResult(1'b0);
        applyStimulus(1'b0, 16'hCC, 16'hAA, 1'b1, 3'b010, 1'b1, 8, "xor");
        checkResult(1'b0, "xor", 16'h66, 1'b0, 1'b0, 1'b0, 1'b0);
        releaseResult(1'b0);
        applyStimulus(1'b0, 16'h81, 16'h00, 1'b1, 3'b101, 1'b1, 8, "shl");
        checkResult(1'b0, "shl", 16'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        releaseResult(1'b0);
        applyStimulus(1'b0, 16'h0F, 16'h00, 1'b1, 3'b011, 1'b1, 8, "nota");
        checkResult(1'b0, "nota", 16'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
        releaseResult(1'b0);

        // Back-pressure: result held while out_ready stays low
        applyStimulus(1'b0, 16'h10, 16'h20, 1'b0, 3'b001, 1'b1, 8, "hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkResult(1'b0, "hold", 16'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput("hold_out_valid", b8.out_valid, 1'b1);
            checkOutput("hold_in_ready", b8.in_ready, 1'b0);
        end
        releaseResult(1'b0);

        // Reset in the third BUSY cycle
        acceptOp(1'b0, 16'h55, 16'h0F, 1'b0, 3'b000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", b8.out_valid, 1'b0);
        checkOutput("midrst_in_ready", b8.in_ready, 1'b1);
        checkOutput("midrst_result", b8.result, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h12, 16'h34, 1'b0, 3'b000, 1'b0, 8, "postrst");
        checkResult(1'b0, "postrst", 16'h46, 1'b0, 1'b0, 1'b0, 1'b0);
        releaseResult(1'b0);

        // Wide instance, 4-bit slices
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 3'b000, 1'b0, 4, "w16");
        checkResult(1'b1, "w16", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        releaseResult(1'b1);
        applyStimulus(1'b1, 16'h8421, 16'h0000, 1'b1, 3'b100, 1'b0, 4, "w16shl");
        checkResult(1'b1, "w16shl", 16'h0842, 1'b1, 1'b0, 1'b0, 1'b0);
        releaseResult(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
